// File: rtl/shake_arbiter_if.sv
// Bundle of requester-side and sponge-side signals around shake_arbiter.
// The arbiter uses the slave modport; the environment (requesters + sponge) uses master.
interface shake_arbiter_if #(
    parameter int NREQ          = 3,
    parameter int DATA_IN_BITS  = 64,
    parameter int DATA_OUT_BITS = 64
);
    localparam int LL_W = $clog2(DATA_IN_BITS) + 1;

    logic [NREQ-1:0]              req;
    logic [NREQ-1:0]              rel;
    logic [NREQ-1:0]              gnt;
    logic [NREQ*DATA_IN_BITS-1:0] r_data_in;
    logic [NREQ-1:0]              r_in_valid;
    logic [NREQ-1:0]              r_in_last;
    logic [NREQ-1:0]              r_out_ready;
    logic [NREQ-1:0]              r_absorb_next;
    logic [NREQ*LL_W-1:0]         r_last_len;
    logic [DATA_OUT_BITS-1:0]     r_data_out;
    logic [NREQ-1:0]              r_out_valid;
    logic [NREQ-1:0]              r_in_ready;
    logic [DATA_IN_BITS-1:0]      shake_data_in;
    logic                         in_valid;
    logic                         in_last;
    logic                         out_ready;
    logic [LL_W-1:0]              last_len;
    logic                         shake_rst;
    logic [DATA_OUT_BITS-1:0]     shake_data_out;
    logic                         out_valid;
    logic                         in_ready;
    logic                         busy;

    modport slave (
        input  req, rel, r_data_in, r_in_valid, r_in_last, r_out_ready,
               r_absorb_next, r_last_len, shake_data_out, out_valid, in_ready,
        output gnt, r_data_out, r_out_valid, r_in_ready, shake_data_in,
               in_valid, in_last, out_ready, last_len, shake_rst, busy
    );

    modport master (
        output req, rel, r_data_in, r_in_valid, r_in_last, r_out_ready,
               r_absorb_next, r_last_len, shake_data_out, out_valid, in_ready,
        input  gnt, r_data_out, r_out_valid, r_in_ready, shake_data_in,
               in_valid, in_last, out_ready, last_len, shake_rst, busy
    );
endinterface

// File: rtl/shake_arbiter.sv
// Shares one SHAKE sponge among NREQ requesters; each grant is preceded by a one-cycle sponge flush.
// Define SHAKE_ARB_RR_EN for round-robin arbitration; otherwise the lowest requesting index wins.
module shake_arbiter #(
    parameter int NREQ          = 3,
    parameter int DATA_IN_BITS  = 64,
    parameter int DATA_OUT_BITS = 64
) (
    input  logic            clk,
    input  logic            rst,
    shake_arbiter_if.slave  bus
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int LL_W  = $clog2(DATA_IN_BITS) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        GRANT = 2'd2
    } state_t;

    state_t                   state_r;
    state_t                   state_s;
    logic [IDX_W-1:0]         winner_r;
    logic [IDX_W-1:0]         pick_s;
    logic                     pick_vld_s;
    logic                     win_req_s;
    logic                     win_rel_s;
    logic                     rst_hold_r;
    logic [NREQ-1:0]          gnt_r;
    logic                     busy_r;
    logic [DATA_IN_BITS-1:0]  data_in_s;
    logic                     in_valid_s;
    logic                     in_last_s;
    logic                     out_ready_s;
    logic [LL_W-1:0]          last_len_s;
    logic                     shake_rst_s;
    logic [NREQ-1:0]          r_out_valid_s;
    logic [NREQ-1:0]          r_in_ready_s;

`ifdef SHAKE_ARB_RR_EN
    logic [IDX_W-1:0] ptr_r;

    // Circular search for the first requester at or after the pointer
    always_comb begin
        int raw;
        int idx;
        raw        = 0;
        idx        = 0;
        pick_s     = '0;
        pick_vld_s = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            raw        = int'(ptr_r) + k;
            idx        = (raw >= NREQ) ? raw - NREQ : raw;
            pick_s     = bus.req[idx] ? IDX_W'(idx) : pick_s;
            pick_vld_s = pick_vld_s | bus.req[idx];
        end
    end

    // Pointer moves just past the winner as the flush starts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_r <= '0;
        end else if (state_r == IDLE && pick_vld_s) begin
            ptr_r <= (int'(pick_s) == NREQ - 1) ? '0 : pick_s + 1'b1;
        end
    end
`else
    // Fixed priority: scan high to low so the lowest requesting index is kept
    always_comb begin
        pick_s     = '0;
        pick_vld_s = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            pick_s     = bus.req[k] ? IDX_W'(k) : pick_s;
            pick_vld_s = pick_vld_s | bus.req[k];
        end
    end
`endif

    // Current winner's own req/rel, so other requesters cannot end the grant
    always_comb begin
        win_req_s = 1'b0;
        win_rel_s = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            win_req_s = (winner_r == IDX_W'(i)) ? bus.req[i] : win_req_s;
            win_rel_s = (winner_r == IDX_W'(i)) ? bus.rel[i] : win_rel_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = pick_vld_s ? FLUSH : IDLE;
            FLUSH:   state_s = GRANT;
            GRANT:   state_s = (win_rel_s || !win_req_s) ? IDLE : GRANT;
            default: state_s = IDLE;
        endcase
    end

    // State, winner latch and registered grant/busy; rst_hold keeps the sponge in reset until the first edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            winner_r   <= '0;
            gnt_r      <= '0;
            busy_r     <= 1'b0;
            rst_hold_r <= 1'b1;
        end else begin
            state_r    <= state_s;
            rst_hold_r <= 1'b0;
            busy_r     <= (state_s != IDLE);
            gnt_r      <= (state_s == GRANT) ? (NREQ'(1) << winner_r) : '0;
            if (state_r == IDLE && pick_vld_s) begin
                winner_r <= pick_s;
            end
        end
    end

    // Sponge-side mux: only the winner's controls reach the sponge, and only during GRANT
    always_comb begin
        data_in_s     = '0;
        in_valid_s    = 1'b0;
        in_last_s     = 1'b0;
        out_ready_s   = 1'b0;
        last_len_s    = '0;
        r_out_valid_s = '0;
        r_in_ready_s  = '0;
        shake_rst_s   = rst_hold_r;
        case (state_r)
            IDLE:  shake_rst_s = rst_hold_r;
            FLUSH: shake_rst_s = 1'b1;
            GRANT: begin
                for (int i = 0; i < NREQ; i++) begin
                    data_in_s        = (winner_r == IDX_W'(i)) ? bus.r_data_in[i*DATA_IN_BITS +: DATA_IN_BITS] : data_in_s;
                    in_valid_s       = (winner_r == IDX_W'(i)) ? bus.r_in_valid[i]    : in_valid_s;
                    in_last_s        = (winner_r == IDX_W'(i)) ? bus.r_in_last[i]     : in_last_s;
                    out_ready_s      = (winner_r == IDX_W'(i)) ? bus.r_out_ready[i]   : out_ready_s;
                    last_len_s       = (winner_r == IDX_W'(i)) ? bus.r_last_len[i*LL_W +: LL_W] : last_len_s;
                    shake_rst_s      = (winner_r == IDX_W'(i)) ? bus.r_absorb_next[i] : shake_rst_s;
                    r_out_valid_s[i] = (winner_r == IDX_W'(i)) & bus.out_valid;
                    r_in_ready_s[i]  = (winner_r == IDX_W'(i)) & bus.in_ready;
                end
            end
            default: shake_rst_s = 1'b1;
        endcase
    end

    assign bus.gnt           = gnt_r;
    assign bus.busy          = busy_r;
    assign bus.shake_rst     = shake_rst_s;
    assign bus.shake_data_in = data_in_s;
    assign bus.in_valid      = in_valid_s;
    assign bus.in_last       = in_last_s;
    assign bus.out_ready     = out_ready_s;
    assign bus.last_len      = last_len_s;
    assign bus.r_out_valid   = r_out_valid_s;
    assign bus.r_in_ready    = r_in_ready_s;
    assign bus.r_data_out    = bus.shake_data_out[DATA_OUT_BITS-1:0];
endmodule

// File: doc/shake_arbiter.md
SHAKE_ARBITER -- requirements
Module: shake_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 3, giving the number of requesters (ExpandA, ExpandS, ExpandMask).
REQ-002 The block SHALL have parameter DATA_IN_BITS, default 64, giving the sponge input width.
REQ-003 The block SHALL have parameter DATA_OUT_BITS, default 64, giving the sponge output width.
REQ-004 The block SHALL have a single clock domain and an asynchronous, active-low reset; port list follows.
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester access request, level
- rel  in  NREQ  per-requester release pulse, one cycle
- gnt  out  NREQ  one-hot grant
- r_data_in  in  NREQ*DATA_IN_BITS  per-requester sponge input
- r_in_valid / r_in_last / r_out_ready / r_absorb_next  in  NREQ each  per-requester sponge controls
- r_last_len  in  NREQ*($clog2(DATA_IN_BITS)+1)  per-requester last length
- r_data_out  out  DATA_OUT_BITS  sponge output, broadcast
- r_out_valid / r_in_ready  out  NREQ each  gated sponge status
- shake_data_in  out  DATA_IN_BITS; in_valid, in_last, out_ready  out  1 each; last_len  out  $clog2(DATA_IN_BITS)+1  to sponge
- shake_rst  out  1  active-high sponge reset
- shake_data_out  in  DATA_OUT_BITS; out_valid, in_ready  in  1 each  from sponge
- busy  out  1  grant held or flush in progress

Function
REQ-005 The FSM SHALL have states IDLE, FLUSH, GRANT.
REQ-006 IDLE: if any req bit is set, the block SHALL latch the winner and go to FLUSH next cycle; gnt stays 0.
REQ-007 FLUSH SHALL last exactly one cycle with shake_rst=1; it then goes to GRANT with gnt one-hot for the winner, so grant latency from req to gnt is 2 cycles.
REQ-008 GRANT: the sponge-side outputs SHALL mux the winner's r_* inputs; r_out_valid/r_in_ready SHALL be 1 only at the winner index; non-winner sponge-side controls are ignored.
REQ-009 In GRANT, shake_rst SHALL equal the winner's r_absorb_next, combinationally.
REQ-010 A rel pulse from the winner, or deassertion of the winner's req, SHALL return the FSM to IDLE next cycle; rel from a non-winner is ignored.
REQ-011 Outside GRANT, in_valid, in_last and out_ready SHALL be 0; shake_data_in, last_len and all r_out_valid/r_in_ready bits SHALL be 0.
REQ-012 r_data_out SHALL equal shake_data_out at all times.
REQ-013 A request arriving in the same cycle as a winner's rel SHALL be arbitrated in the following IDLE cycle; IDLE always lasts at least one cycle between grants.
REQ-014 busy SHALL be 1 in FLUSH and GRANT.

Reset
REQ-015 While rst=0, the FSM SHALL be in IDLE with gnt=0, busy=0, shake_rst=1 and all sponge-side controls 0, asynchronously.
REQ-016 On rst rising, shake_rst SHALL drop at the first clk edge; arbitration SHALL resume from priority pointer 0.
REQ-017 Reset during GRANT SHALL drop gnt immediately with no flush cycle required afterward beyond the normal FLUSH.

Configuration
REQ-018 With SHAKE_ARB_RR_EN defined, the arbiter SHALL be round-robin: the pointer advances to winner+1 mod NREQ on entering FLUSH, and the search starts at the pointer.
REQ-019 Without SHAKE_ARB_RR_EN, the arbiter SHALL be fixed priority, with the lowest index winning.

Verification
REQ-020 req=3'b001 from IDLE -> shake_rst=1 in cycle 1, gnt=3'b001 in cycle 2; 17 absorbed words pass through; r_in_ready[1,2] stay 0.
REQ-021 req=3'b110 simultaneously -> gnt=3'b010; after rel[1], gnt=3'b100 exactly 3 cycles after the rel cycle (IDLE, FLUSH, GRANT).
REQ-022 RR build: req held at 3'b111 with rel after each 4 outputs -> grant order 001,010,100,001; fixed-priority build -> 001,001,001.
REQ-023 Winner asserts r_absorb_next mid-GRANT -> shake_rst=1 that same cycle and gnt unchanged.
REQ-024 rst=0 asserted while gnt=3'b010 with in_valid=1 -> gnt=0, in_valid=0, shake_rst=1 without waiting for clk.
REQ-025 rel[2] pulsed while gnt=3'b001 -> no state change; non-winner r_in_valid=1 -> in_valid follows the winner only.
